// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N_CH producers, the packet mux and a single consumer.
// Valid/ready: a beat transfers on a rising edge where valid && ready; the sender holds data/last stable while valid && !ready.
interface rr_stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
);
  logic [N_CH-1:0]       s_valid;
  logic [N_CH*WIDTH-1:0] s_data;
  logic [N_CH-1:0]       s_last;
  logic [N_CH-1:0]       s_ready;
  logic                  m_valid;
  logic [WIDTH-1:0]      m_data;
  logic                  m_last;
  logic [SEL_W-1:0]      m_chan;
  logic                  m_ready;

  // master: the mux, which drives the shared output stream and the per-channel ready.
  modport master (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last, m_chan
  );

  // slave: the surrounding producers and consumer.
  modport slave (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last, m_chan
  );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel packet stream mux: round-robin or fixed channel select, packet-locked,
// with a registered output stage.
module rr_stream_mux #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic [SEL_W-1:0] fix_sel,
  rr_stream_mux_if.master  bus,
  output logic             dbg_state
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] grant, grant_nx;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_nx;
  logic [N_CH-1:0]  elig;
  logic             found;
  logic [SEL_W-1:0] pick;
  int               idx;
  logic             out_free;
  logic             acc;
  logic [WIDTH-1:0] sel_data;

  assign dbg_state = state;
  assign out_free  = !bus.m_valid || bus.m_ready;
  assign acc       = (state == LOCK) && bus.s_valid[grant] && out_free;

  // In fixed mode only the selected channel is eligible, so the same upward
  // search serves both modes; an out-of-range fix_sel leaves the set empty.
  always_comb begin
    elig = '0;
    if (!mode) begin
      elig = bus.s_valid;
    end else if (int'(fix_sel) < N_CH) begin
      elig[fix_sel] = bus.s_valid[fix_sel];
    end
  end

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = (int'(rr_ptr) + k) % N_CH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = SEL_W'(idx);
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant == SEL_W'(i)) sel_data = bus.s_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    bus.s_ready = '0;
    if (state == LOCK) bus.s_ready[grant] = out_free;
  end

  always_comb begin
    state_nx  = state;
    grant_nx  = grant;
    rr_ptr_nx = rr_ptr;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nx = pick;
          state_nx = LOCK;
        end
      end
      LOCK: begin
        if (acc && bus.s_last[grant]) begin
          state_nx  = IDLE;
          rr_ptr_nx = grant;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // rr_ptr resets to the top channel so that channel 0 wins the first search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= SEL_W'(N_CH - 1);
    end else begin
      state  <= state_nx;
      grant  <= grant_nx;
      rr_ptr <= rr_ptr_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_last  <= 1'b0;
      bus.m_chan  <= '0;
    end else if (acc) begin
      bus.m_valid <= 1'b1;
      bus.m_data  <= sel_data;
      bus.m_last  <= bus.s_last[grant];
      bus.m_chan  <= grant;
    end else if (bus.m_ready) begin
      bus.m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a cycle table for round-robin arbitration plus
// scripted packet sequences checked against an expected-beat queue.
module tb_rr_stream_mux;
  localparam int WIDTH = 8;
  localparam int N_CH  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [1:0] fix_sel = 2'd0;
  logic       dbg_state;

  rr_stream_mux_if #(.WIDTH(WIDTH), .N_CH(N_CH)) bus ();

  rr_stream_mux #(.WIDTH(WIDTH), .N_CH(N_CH)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .fix_sel(fix_sel),
    .bus(bus), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] last;
    logic [3:0] exp_ready;
    logic       exp_state;
    logic       exp_mv;
    logic [1:0] exp_ch;
    logic [7:0] exp_md;
    logic       exp_ml;
  } vec_t;

  vec_t tab[16];

  logic [10:0] exp_q[$];          // {chan, last, data}
  logic [8:0]  tx_mem[N_CH][16];  // {last, data}
  int          tx_rd[N_CH];
  int          tx_wr[N_CH];
  logic [3:0]  en = 4'b1111;
  logic        use_tab = 1'b1;
  logic        sb_on = 1'b0;
  logic [3:0]  ready_pre;
  int          n;

  function automatic vec_t mk(logic [3:0] v, logic [3:0] l, logic [3:0] er, logic es,
                              logic mv, logic [1:0] ch, logic [7:0] md, logic ml);
    vec_t r;
    r.valid = v; r.last = l; r.exp_ready = er; r.exp_state = es;
    r.exp_mv = mv; r.exp_ch = ch; r.exp_md = md; r.exp_ml = ml;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_tx();
    for (int c = 0; c < N_CH; c++) begin
      tx_rd[c] = 0;
      tx_wr[c] = 0;
    end
  endtask

  task automatic push_tx(input int ch, input logic [7:0] d, input logic l);
    tx_mem[ch][tx_wr[ch]] = {l, d};
    tx_wr[ch]++;
  endtask

  task automatic push_exp(input int ch, input logic [7:0] d, input logic l);
    exp_q.push_back({2'(ch), l, d});
  endtask

  task automatic drive_prod();
    logic [8:0] w;
    for (int c = 0; c < N_CH; c++) begin
      if (tx_rd[c] < tx_wr[c]) begin
        w = tx_mem[c][tx_rd[c]];
        bus.s_valid[c] = en[c];
        bus.s_data[c*WIDTH +: WIDTH] = w[7:0];
        bus.s_last[c] = w[8];
      end else begin
        bus.s_valid[c] = 1'b0;
        bus.s_data[c*WIDTH +: WIDTH] = 8'h00;
        bus.s_last[c] = 1'b0;
      end
    end
  endtask

  // One clock: drive, sample s_ready, score/pop just before the edge, return after it.
  task automatic cycle();
    logic [10:0] e;
    if (!use_tab) drive_prod();
    @(negedge clk);
    #1 ready_pre = bus.s_ready;
    #3;
    if (rst_n) begin
      if (sb_on && bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got chan %0d last %0b data %0h, required no beat",
                   bus.m_chan, bus.m_last, bus.m_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.m_chan, bus.m_last, bus.m_data} !== e) begin
            errors++;
            $display("FAIL sb_beat: got chan %0d last %0b data %0h, required chan %0d last %0b data %0h",
                     bus.m_chan, bus.m_last, bus.m_data, e[10:9], e[8], e[7:0]);
          end
        end
      end
      if (!use_tab) begin
        for (int c = 0; c < N_CH; c++)
          if (bus.s_valid[c] && bus.s_ready[c]) tx_rd[c]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output int cnt);
    cnt = 0;
    while (exp_q.size() > 0 && cnt < budget) begin
      cycle();
      cnt++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  // ---------------- test ----------------
  initial begin
    bus.s_valid = '0;
    bus.s_data  = '0;
    bus.s_last  = '0;
    bus.m_ready = 1'b0;
    clear_tx();

    // Two-beat packets on all channels, data C0|ch, m_ready held high.
    tab[0]  = mk(4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    tab[1]  = mk(4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hC0, 1'b0);
    tab[2]  = mk(4'hF, 4'h1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hC0, 1'b1);
    tab[3]  = mk(4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 2'd0, 8'hC0, 1'b1);
    tab[4]  = mk(4'hF, 4'h0, 4'b0010, 1'b1, 1'b1, 2'd1, 8'hC1, 1'b0);
    tab[5]  = mk(4'hF, 4'h2, 4'b0010, 1'b0, 1'b1, 2'd1, 8'hC1, 1'b1);
    tab[6]  = mk(4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 2'd1, 8'hC1, 1'b1);
    tab[7]  = mk(4'hF, 4'h0, 4'b0100, 1'b1, 1'b1, 2'd2, 8'hC2, 1'b0);
    tab[8]  = mk(4'hF, 4'h4, 4'b0100, 1'b0, 1'b1, 2'd2, 8'hC2, 1'b1);
    tab[9]  = mk(4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 2'd2, 8'hC2, 1'b1);
    tab[10] = mk(4'hF, 4'h0, 4'b1000, 1'b1, 1'b1, 2'd3, 8'hC3, 1'b0);
    tab[11] = mk(4'hF, 4'h8, 4'b1000, 1'b0, 1'b1, 2'd3, 8'hC3, 1'b1);
    tab[12] = mk(4'hF, 4'h0, 4'b0000, 1'b1, 1'b0, 2'd3, 8'hC3, 1'b1);
    tab[13] = mk(4'hF, 4'h0, 4'b0001, 1'b1, 1'b1, 2'd0, 8'hC0, 1'b0);
    tab[14] = mk(4'hF, 4'h1, 4'b0001, 1'b0, 1'b1, 2'd0, 8'hC0, 1'b1);
    tab[15] = mk(4'h0, 4'h0, 4'b0000, 1'b0, 1'b0, 2'd0, 8'hC0, 1'b1);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data",  32'(bus.m_data),  32'd0);
    check("rst_m_last",  32'(bus.m_last),  32'd0);
    check("rst_m_chan",  32'(bus.m_chan),  32'd0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_state",   32'(dbg_state),   32'd0);
    rst_n = 1'b1;

    // Round-robin table
    use_tab = 1'b1;
    bus.m_ready = 1'b1;
    bus.s_data = 32'hC3C2C1C0;
    for (int i = 0; i < 16; i++) begin
      bus.s_valid = tab[i].valid;
      bus.s_last  = tab[i].last;
      cycle();
      check($sformatf("tab%0d_s_ready", i), 32'(ready_pre), 32'(tab[i].exp_ready));
      check($sformatf("tab%0d_state", i), 32'(dbg_state), 32'(tab[i].exp_state));
      check($sformatf("tab%0d_m_out", i), {21'd0, bus.m_valid, bus.m_chan, bus.m_data},
            {21'd0, tab[i].exp_mv, tab[i].exp_ch, tab[i].exp_md});
      check($sformatf("tab%0d_m_last", i), 32'(bus.m_last), 32'(tab[i].exp_ml));
    end

    // Packet lock: ch1 has a one-cycle valid gap while ch2 waits
    use_tab = 1'b0;
    sb_on = 1'b1;
    clear_tx();
    en = 4'b1111;
    push_tx(1, 8'h11, 1'b0); push_tx(1, 8'h12, 1'b0); push_tx(1, 8'h13, 1'b1);
    push_tx(2, 8'h21, 1'b1);
    push_exp(1, 8'h11, 1'b0); push_exp(1, 8'h12, 1'b0); push_exp(1, 8'h13, 1'b1);
    push_exp(2, 8'h21, 1'b1);
    cycle(); cycle();
    en = 4'b1101;
    cycle();
    check("lock_gap_s_ready", 32'(ready_pre), 32'b0010);
    check("lock_gap_state", 32'(dbg_state), 32'd1);
    en = 4'b1111;
    drain(20, n);

    // Sparse wrap from rr_ptr=2: ch3, ch0, ch3 with single-beat packets
    clear_tx();
    push_tx(3, 8'h31, 1'b1); push_tx(3, 8'h33, 1'b1); push_tx(0, 8'h30, 1'b1);
    push_exp(3, 8'h31, 1'b1); push_exp(0, 8'h30, 1'b1); push_exp(3, 8'h33, 1'b1);
    drain(20, n);
    check("wrap_cycles", 32'(n), 32'd7);

    // Fixed select ch2, retarget to ch3 mid-packet
    clear_tx();
    mode = 1'b1;
    fix_sel = 2'd2;
    push_tx(2, 8'h20, 1'b0); push_tx(2, 8'h21, 1'b1);
    push_tx(2, 8'h22, 1'b0); push_tx(2, 8'h23, 1'b1);
    push_tx(3, 8'h38, 1'b0); push_tx(3, 8'h39, 1'b1);
    push_tx(0, 8'h0A, 1'b1); push_tx(1, 8'h1A, 1'b1);
    push_exp(2, 8'h20, 1'b0); push_exp(2, 8'h21, 1'b1);
    push_exp(2, 8'h22, 1'b0); push_exp(2, 8'h23, 1'b1);
    push_exp(3, 8'h38, 1'b0); push_exp(3, 8'h39, 1'b1);
    repeat (5) cycle();
    fix_sel = 2'd3;
    drain(30, n);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check($sformatf("fix_idle%0d_m_valid", i), 32'(bus.m_valid), 32'd0);
      check($sformatf("fix_idle%0d_state", i), 32'(dbg_state), 32'd0);
    end
    mode = 1'b0;
    push_exp(0, 8'h0A, 1'b1); push_exp(1, 8'h1A, 1'b1);
    drain(20, n);

    // Backpressure: 5 stalled cycles holding 8'h5A
    clear_tx();
    push_tx(2, 8'h5A, 1'b0); push_tx(2, 8'h5B, 1'b0); push_tx(2, 8'h5C, 1'b1);
    push_tx(3, 8'h3C, 1'b1);
    push_exp(2, 8'h5A, 1'b0); push_exp(2, 8'h5B, 1'b0); push_exp(2, 8'h5C, 1'b1);
    push_exp(3, 8'h3C, 1'b1);
    cycle(); cycle();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("bp%0d_s_ready", i), 32'(ready_pre), 32'd0);
      check($sformatf("bp%0d_m_out", i), {22'd0, bus.m_valid, bus.m_last, bus.m_chan, bus.m_data},
            {22'd0, 1'b1, 1'b0, 2'd2, 8'h5A});
    end
    bus.m_ready = 1'b1;
    drain(20, n);

    // Reset mid-packet with m_valid=1 and rr_ptr moved off its reset value
    clear_tx();
    push_tx(1, 8'h6F, 1'b1);
    push_exp(1, 8'h6F, 1'b1);
    drain(20, n);
    clear_tx();
    push_tx(2, 8'h70, 1'b0); push_tx(2, 8'h71, 1'b0); push_tx(2, 8'h72, 1'b1);
    cycle(); cycle();
    check("pre_rst_m_valid", 32'(bus.m_valid), 32'd1);
    check("pre_rst_m_chan", 32'(bus.m_chan), 32'd2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_m_chan",  32'(bus.m_chan),  32'd0);
    check("mid_rst_m_data",  32'(bus.m_data),  32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("mid_rst_state",   32'(dbg_state),   32'd0);
    clear_tx();
    exp_q.delete();
    cycle();
    rst_n = 1'b1;
    for (int c = 0; c < N_CH; c++) begin
      push_tx(c, 8'h80 + 8'(c), 1'b1);
      push_exp(c, 8'h80 + 8'(c), 1'b1);
    end
    drain(30, n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel packet stream multiplexer. Successor to the combinational 4:1 select mux.
- Selects one of N_CH valid/ready input streams, either by round-robin arbitration or by a fixed software-style select.
- Holds the selected channel until the end of its packet (last), then re-arbitrates.
- Drives a registered output stage. Sits between per-channel producers and a single shared consumer (e.g. one datapath unit fed by several sources).

Parameters:
WIDTH, 8, data width per channel in bits
N_CH, 4, number of input channels (>=2)
SEL_W, $clog2(N_CH), channel index width (derived; do not override)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = round-robin arbitration, 1 = fixed select via fix_sel
fix_sel  input  SEL_W  channel forced when mode=1
s_valid  input  N_CH  per-channel beat valid
s_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
s_last  input  N_CH  per-channel end-of-packet marker
s_ready  output  N_CH  per-channel beat accept
m_valid  output  1  output beat valid (registered)
m_data  output  WIDTH  output beat data (registered)
m_last  output  1  output end-of-packet (registered)
m_chan  output  SEL_W  source channel of current output beat (registered)
m_ready  input  1  downstream accept

Behaviour:
- Reset: one clock, clk. Reset is asynchronous and active-low, rst_n. While rst_n=0:
  - m_valid=0, m_data=0, m_last=0, m_chan=0, s_ready=0.
  - state=IDLE, grant=0, rr_ptr=N_CH-1, so channel 0 has first priority.
- FSM, 2 states:
  - IDLE: eligible set = s_valid (mode=0) or only s_valid[fix_sel] (mode=1).
    - If the set is non-empty, register grant and go to LOCK.
    - mode=0 grant: first valid channel searching upward from rr_ptr+1, wrapping modulo N_CH.
    - No beat is accepted in IDLE; s_ready=0.
  - LOCK: s_ready[grant] = (!m_valid || m_ready); all other s_ready bits are 0.
    - Accepted beat: s_valid[grant] && s_ready[grant].
    - On an accepted beat with s_last[grant]=1: go to IDLE; rr_ptr <= grant.
- Output register: loads on an accepted beat.
  - m_data <= s_data[grant], m_last <= s_last[grant], m_chan <= grant, m_valid <= 1.
  - If there is no accepted beat and m_ready=1, m_valid <= 0.
  - m_data, m_last and m_chan hold while m_valid && !m_ready.
- Latency and throughput:
  - An accepted beat appears on m_* one cycle later.
  - Sustained 1 beat/cycle within a packet when m_ready=1.
  - Each packet costs one extra IDLE cycle for arbitration.
  - Single-beat packets therefore run at 1 beat per 2 cycles.
- Backpressure: with m_valid=1 and m_ready=0, no beat is accepted and the output is stable. Stability of m_* under stall is mandatory.
- Mode or fix_sel changes are sampled only in IDLE. Changes during LOCK do not affect the current packet.
- mode=1 with fix_sel >= N_CH (non-power-of-2 N_CH): the eligible set is empty; stay in IDLE.
- Grant wrap: with rr_ptr=N_CH-1, the search starts at channel 0.
- A grant is only made to a channel with s_valid=1. A granted channel deasserting s_valid mid-packet simply stalls LOCK. No timeout.
- Reset mid-packet: immediate return to reset values. Partial packet is dropped; no recovery.
- Producers must hold s_data/s_last stable while s_valid && !s_ready (standard valid/ready).

Test Plan:
- Reset check: assert rst_n=0 mid-stream with m_valid=1 -> m_valid, m_chan and s_ready go to 0 asynchronously. After release, the first grant goes to channel 0 when all 4 channels are valid.
- Round-robin fairness: mode=0; all 4 channels continuously send 2-beat packets (data = 8'hC0|ch) -> m_chan order 0,1,2,3,0,…. Each packet is 2 contiguous beats with m_last on the 2nd. No interleaving.
- Packet lock: ch1 sends a 3-beat packet with a 1-cycle s_valid gap mid-packet while ch2 is valid -> ch2 is not granted until ch1's last beat is accepted. Output is 3 ch1 beats, then ch2.
- Fixed select: mode=1, fix_sel=2, all channels valid -> only ch2 packets are output. Switch fix_sel to 3 mid-packet -> the current ch2 packet completes, then ch3 follows.
- Backpressure: hold m_ready=0 for 5 cycles with m_valid=1, data 8'h5A -> m_data stays 8'h5A and s_ready=0. On release, data continues with no loss or duplication (scoreboard per channel).
- Sparse wrap: mode=0, only ch3 and ch0 valid, rr_ptr=2 -> grant ch3, then ch0, then ch3.
